adc_scan_ctrl: RTL
==================

# adc_scan_ctrl

Multi-channel scan sequencer for the 10-bit ADC. It drives the analog mux select, waits a programmable settling time, strobes a conversion, and captures `dout` from the ADC. It returns each result with its channel tag over a valid/ready handshake. It sits between the ADC and the digital consumer (DAC loopback / result FIFO) and owns all ADC timing.

## Interface
Parameters:
- `NCH`, 4: number of analog channels (2..16).
- `CH_W`, 2: channel index width, equal to clog2(`NCH`).
- `SETTLE`, 3: mux settling cycles before sampling (≥1).

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scan. Sampled only in IDLE.
- `cont` in 1: continuous mode. Sampled at the end of each scan.
- `abort` in 1: synchronous scan abort.
- `ch_en` in `NCH`: channel enable mask. Latched at accepted `start`.
- `mux_sel` out `CH_W`: analog mux select.
- `adc_sample` out 1: one-cycle conversion strobe.
- `adc_dout` in 10: ADC result, valid one cycle after `adc_sample`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 10: conversion result.
- `res_ch` out `CH_W`: channel of `res_data`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, SETTLE, SAMPLE, CAPTURE and OUTPUT.
- IDLE: `start`=1 with `ch_en`≠0 latches the mask and selects the lowest enabled channel (`mux_sel` updated at the same edge), then → SETTLE. If `ch_en`=0, `start` is ignored.
- SETTLE: counter runs for `SETTLE` cycles, then → SAMPLE.
- SAMPLE: `adc_sample`=1 for exactly one cycle, then → CAPTURE.
- CAPTURE: at the exiting edge, `adc_dout` is registered into `res_data` and `mux_sel` into `res_ch`, then → OUTPUT.
- OUTPUT: `res_valid`=1. `res_data`/`res_ch` are held stable until the transfer edge (`res_valid`&`res_ready`). At the transfer edge:
  - if a higher-index enabled channel remains in the latched mask, select it → SETTLE;
  - else if `cont`=1, select the lowest latched channel → SETTLE;
  - else → IDLE.
- Channels are visited in ascending index order. Disabled channels are skipped with zero cycles spent. Changes to `ch_en` mid-scan have no effect.
- `start` while `busy` is ignored.
- `abort`=1 in any non-IDLE state → IDLE at the next edge and `res_valid` drops. An untransferred result is discarded. `abort` has priority over the transfer and over `start`.
- Async reset mid-operation: immediate IDLE. All outputs are 0, including `mux_sel`, `res_data`, `res_ch`, `res_valid`, `adc_sample` and `busy`. Latched mask and counters are cleared.

## Timing
- `start` accepted at edge E:
  - `adc_sample` is high in the cycle after edge E+`SETTLE`;
  - `res_valid` rises after edge E+`SETTLE`+2.
- Channel-to-channel time equals `SETTLE`+3 cycles when `res_ready` is held at 1.
- `res_ready` backpressure stalls only in OUTPUT. `mux_sel` does not change while stalled.
- `adc_sample` never asserts while `res_valid`=1.
- `busy` drops in the same cycle the FSM enters IDLE.

## Configuration
- `ADC_SCAN_AVG_EN` defined: each channel is converted 4 times.
  - One SETTLE, then 4×(SAMPLE, CAPTURE) back-to-back.
  - Samples are summed into a 12-bit unsigned accumulator, cleared on entering SETTLE.
  - `res_data` = acc[11:2], i.e. truncated mean with no rounding.
  - `res_valid` rises after edge E+`SETTLE`+8.
- `ADC_SCAN_AVG_EN` undefined: single conversion per channel, as described above. No accumulator is synthesized.

## Test plan
- Reset: `rst_n`=0 mid-SETTLE → all outputs 0 immediately. After release with `start`=0, the block stays in IDLE and `busy`=0.
- Single scan: `NCH`=4, `SETTLE`=3, `ch_en`=4'b1011, ADC returns 100/200/300 on ch0/1/3, `res_ready`=1 → results (0,100), (1,200), (3,300). Channel 2 is never selected. First `res_valid` is high after edge E+5, and `busy` falls after the third transfer.
- Backpressure: hold `res_ready`=0 for 10 cycles in OUTPUT → `res_data`/`res_ch`/`mux_sel` are stable and no `adc_sample` is issued. The transfer happens on the first edge with `res_ready`=1.
- Continuous + abort: `cont`=1, `ch_en`=4'b0110 → sequence 1, 2, 1, 2, …. Assert `abort` during OUTPUT with `res_ready`=1 → no transfer counted, IDLE next cycle, `res_valid`=0.
- Edge cases:
  - `start` with `ch_en`=0 → stays IDLE.
  - `start` pulse while busy → no restart and sequence unchanged.
  - ADC code 1023 → `res_data`=1023.
- `ADC_SCAN_AVG_EN`: samples 1020, 1021, 1022, 1023 → `res_data`=1021, valid after edge E+`SETTLE`+8.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan sequencer: mux select, settle, sample strobe, capture, valid/ready result.
// Define ADC_SCAN_AVG_EN to convert each channel four times and return the truncated mean.
module adc_scan_ctrl #(
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int SETTLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [NCH-1:0]    ch_en,
  output logic [CH_W-1:0]   mux_sel,
  output logic              adc_sample,
  input  logic [9:0]        adc_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [9:0]        res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              busy
);

  localparam int DATA_W = 10;
  localparam int CNT_W  = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t           state;
  logic [NCH-1:0]   mask;
  logic [CNT_W-1:0] cnt;
  logic [CH_W:0]    next_hi;
`ifdef ADC_SCAN_AVG_EN
  logic [11:0]      acc;
  logic [1:0]       smp;
`endif

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) r = CH_W'(i);
    return r;
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur
  function automatic logic [CH_W:0] next_above(input logic [NCH-1:0] m, input logic [CH_W-1:0] cur);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

`ifdef ADC_SCAN_AVG_EN
  function automatic logic [DATA_W-1:0] mean4(input logic [11:0] sum);
    return sum[11:2];
  endfunction
`endif

  assign next_hi = next_above(mask, mux_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mask       <= '0;
      cnt        <= '0;
      mux_sel    <= '0;
      adc_sample <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ch     <= '0;
      busy       <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc        <= '0;
      smp        <= '0;
`endif
    end else if (abort && (state != S_IDLE)) begin
      state      <= S_IDLE;
      adc_sample <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (|ch_en)) begin
            mask    <= ch_en;
            mux_sel <= lowest_ch(ch_en);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_SETTLE;
          end
        end
        // ---- mux settling ----
        S_SETTLE: begin
`ifdef ADC_SCAN_AVG_EN
          acc <= '0;
          smp <= '0;
`endif
          if (cnt == CNT_W'(SETTLE - 1)) begin
            adc_sample <= 1'b1;
            state      <= S_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // ---- conversion strobe ----
        S_SAMPLE: begin
          adc_sample <= 1'b0;
          state      <= S_CAPTURE;
        end
        // ---- ADC result capture ----
        S_CAPTURE: begin
`ifdef ADC_SCAN_AVG_EN
          if (smp == 2'd3) begin
            res_data  <= mean4(acc + {2'b00, adc_dout});
            res_ch    <= mux_sel;
            res_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            acc        <= acc + {2'b00, adc_dout};
            smp        <= smp + 2'd1;
            adc_sample <= 1'b1;
            state      <= S_SAMPLE;
          end
`else
          res_data  <= adc_dout;
          res_ch    <= mux_sel;
          res_valid <= 1'b1;
          state     <= S_OUTPUT;
`endif
        end
        // ---- result handshake ----
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (next_hi[CH_W]) begin
              mux_sel <= next_hi[CH_W-1:0];
              cnt     <= '0;
              state   <= S_SETTLE;
            end else if (cont) begin
              mux_sel <= lowest_ch(mask);
              cnt     <= '0;
              state   <= S_SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          adc_sample <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
